// File: rtl/ibex_rf_pkg.sv
// Shared types and helpers for the multi-port register file and its init sequencer.
package ibex_rf_pkg;

    typedef enum logic {RfInit, RfReady} rf_init_e;

    // Widest word the parity helper accepts; narrower words are zero-extended.
    localparam int unsigned RfMaxWidth = 256;

    function automatic int unsigned rf_addr_width(input int unsigned num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    function automatic logic rf_parity(input logic [RfMaxWidth-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ibex_register_file_mp_init.sv
// Post-reset sweep sequencer: walks every word address once so the storage flops
// can be cleared through the normal write path instead of a reset net.
module ibex_register_file_mp_init
    import ibex_rf_pkg::*;
#(
    parameter int unsigned NumWords = 32,
    parameter int unsigned AW       = rf_addr_width(NumWords)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic          init_busy,
    output logic          init_we,
    output logic [AW-1:0] init_addr
);

    localparam logic [AW-1:0] LastAddr = AW'(NumWords - 1);

    rf_init_e      state_q;
    logic          busy_q;
    logic [AW-1:0] cnt_q;

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RfInit;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
        end else if (state_q == RfInit) begin
            if (cnt_q == LastAddr) begin
                state_q <= RfReady;
                busy_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_q + AW'(1);
            end
        end
    end

    assign init_busy = busy_q;
    assign init_we   = busy_q;
    assign init_addr = cnt_q;

endmodule

// File: rtl/ibex_register_file_mp.sv
// Parametrised multi-port flip-flop register file with init sweep, optional
// write-to-read bypass, per-word parity and a hard-wired zero word.
module ibex_register_file_mp
    import ibex_rf_pkg::*;
#(
    parameter int unsigned          NumWords      = 32,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          NumRead       = 2,
    parameter int unsigned          NumWrite      = 1,
    parameter bit                   WriteBypass   = 1'b0,
    parameter bit                   ParityEn      = 1'b0,
    parameter bit                   HardZeroWord0 = 1'b1,
    parameter logic [DataWidth-1:0] WordZeroVal   = '0,
    localparam int unsigned         AW            = rf_addr_width(NumWords)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumRead*AW-1:0]         raddr_i,
    output logic [NumRead*DataWidth-1:0]  rdata_o,
    input  logic [NumWrite*AW-1:0]        waddr_i,
    input  logic [NumWrite*DataWidth-1:0] wdata_i,
    input  logic [NumWrite-1:0]           we_i,
    output logic                          init_busy_o,
    output logic                          err_o
);

    localparam bit HasHoles = (NumWords < (32'd1 << AW));

    logic          init_busy;
    logic          init_we;
    logic [AW-1:0] init_addr;

    ibex_register_file_mp_init #(
        .NumWords (NumWords),
        .AW       (AW)
    ) u_init (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .init_busy (init_busy),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    // ---------------------------------------------------------------- write ports
    logic [AW-1:0]        wr_addr [NumWrite];
    logic [DataWidth-1:0] wr_data [NumWrite];
    logic [NumWrite-1:0]  wr_oor;
    logic [NumWrite-1:0]  wr_ok;
    logic                 collision;

    for (genvar w = 0; w < NumWrite; w++) begin : g_wport
        logic oor;
        assign wr_addr[w] = waddr_i[w*AW +: AW];
        assign wr_data[w] = wdata_i[w*DataWidth +: DataWidth];
        if (HasHoles) begin : g_oor
            assign oor = 32'(wr_addr[w]) >= NumWords;
        end else begin : g_full
            assign oor = 1'b0;
        end
        assign wr_oor[w] = we_i[w] && oor;
        // A write that survives here is guaranteed to land in a real, writable word.
        assign wr_ok[w]  = we_i[w] && !init_busy && !oor &&
                           !(HardZeroWord0 && (wr_addr[w] == '0));
    end

    if (NumWrite > 1) begin : g_coll
        assign collision = we_i[0] && we_i[1] && (wr_addr[0] == wr_addr[1]);
    end else begin : g_no_coll
        assign collision = 1'b0;
    end

    // ---------------------------------------------------------------- storage
    logic [DataWidth-1:0] rd_word [NumWords];
    logic                 rd_par  [NumWords];

    for (genvar i = 0; i < NumWords; i++) begin : g_word
        logic                 we_word;
        logic [DataWidth-1:0] wd_word;
        logic [DataWidth-1:0] mem_q;

        // Port order doubles as priority: the last matching port overrides earlier ones.
        always_comb begin
            we_word = 1'b0;
            wd_word = WordZeroVal;
            if (init_we) begin
                we_word = (init_addr == AW'(i));
            end else begin
                for (int w = 0; w < NumWrite; w++) begin
                    if (wr_ok[w] && (wr_addr[w] == AW'(i))) begin
                        we_word = 1'b1;
                        wd_word = wr_data[w];
                    end
                end
            end
        end

        // NOTE: storage flops have no reset; the init sweep clears them, which keeps
        // the reset net off every data bit.
        always_ff @(posedge clk_i) begin
            if (we_word) begin
                mem_q <= wd_word;
            end
        end

        if (ParityEn) begin : g_par
            logic par_q;
            always_ff @(posedge clk_i) begin
                if (we_word) begin
                    par_q <= rf_parity(RfMaxWidth'(wd_word));
                end
            end
            assign rd_par[i] = par_q;
        end else begin : g_no_par
            assign rd_par[i] = 1'b0;
        end

        assign rd_word[i] = mem_q;
    end

    // ---------------------------------------------------------------- read ports
    logic [NumRead-1:0] rd_oor;
    logic [NumRead-1:0] rd_perr;

    for (genvar p = 0; p < NumRead; p++) begin : g_rport
        logic [AW-1:0]        addr;
        logic                 oor;
        logic                 zero_word;
        logic                 hit;
        logic [DataWidth-1:0] byp_data;
        logic [DataWidth-1:0] data;
        logic                 perr;

        assign addr      = raddr_i[p*AW +: AW];
        assign zero_word = HardZeroWord0 && (addr == '0);
        if (HasHoles) begin : g_oor
            assign oor = 32'(addr) >= NumWords;
        end else begin : g_full
            assign oor = 1'b0;
        end

        // NOTE: every signal assigned in this always_comb gets a default first, so no
        // path can leave it holding a value and infer a latch.
        always_comb begin
            hit      = 1'b0;
            byp_data = WordZeroVal;
            perr     = 1'b0;
            for (int w = 0; w < NumWrite; w++) begin
                if (WriteBypass && wr_ok[w] && (wr_addr[w] == addr)) begin
                    hit      = 1'b1;
                    byp_data = wr_data[w];
                end
            end
            if (init_busy || zero_word || oor) begin
                data = WordZeroVal;
            end else if (hit) begin
                data = byp_data;
            end else begin
                data = rd_word[addr];
            end
            // Parity is checked against the stored word even when the bypass wins.
            if (ParityEn && !init_busy && !zero_word && !oor) begin
                perr = rf_parity(RfMaxWidth'(rd_word[addr])) != rd_par[addr];
            end
        end

        assign rdata_o[p*DataWidth +: DataWidth] = data;
        assign rd_oor[p]  = oor;
        assign rd_perr[p] = perr;
    end

    assign init_busy_o = init_busy;
    assign err_o       = !init_busy && (collision || (|wr_oor) || (|rd_oor) || (|rd_perr));

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor compares them.
module tb_ibex_register_file_mp;

    logic clk;

    // dut_a: 32 words, 2 write ports, no bypass, parity on
    logic        rst_a_n;
    logic [9:0]  raddr_a, waddr_a;
    logic [63:0] rdata_a, wdata_a;
    logic [1:0]  we_a;
    logic        busy_a, err_a;

    // dut_b: 24 words, 2 write ports, bypass on, parity off
    logic        rst_b_n;
    logic [9:0]  raddr_b, waddr_b;
    logic [63:0] rdata_b, wdata_b;
    logic [1:0]  we_b;
    logic        busy_b, err_b;

    ibex_register_file_mp #(
        .NumWords(32), .DataWidth(32), .NumRead(2), .NumWrite(2),
        .WriteBypass(1'b0), .ParityEn(1'b1), .HardZeroWord0(1'b1)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_a_n), .raddr_i(raddr_a), .rdata_o(rdata_a),
        .waddr_i(waddr_a), .wdata_i(wdata_a), .we_i(we_a),
        .init_busy_o(busy_a), .err_o(err_a)
    );

    ibex_register_file_mp #(
        .NumWords(24), .DataWidth(32), .NumRead(2), .NumWrite(2),
        .WriteBypass(1'b1), .ParityEn(1'b0), .HardZeroWord0(1'b1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_b_n), .raddr_i(raddr_b), .rdata_o(rdata_b),
        .waddr_i(waddr_b), .wdata_i(wdata_b), .we_i(we_b),
        .init_busy_o(busy_b), .err_o(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observation selectors
    localparam int SelRd0 = 0, SelRd1 = 1, SelErr = 2, SelBusy = 3;

    typedef struct {
        string       name;
        int          dut;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic expect_val(input string name, input int dut, input int sel,
                              input logic [31:0] v);
        sb_q.push_back('{name, dut, sel, v});
    endtask

    function automatic logic [31:0] actual(input int dut, input int sel);
        logic [63:0] rd;
        logic        er, bz;
        rd = (dut == 0) ? rdata_a : rdata_b;
        er = (dut == 0) ? err_a : err_b;
        bz = (dut == 0) ? busy_a : busy_b;
        case (sel)
            SelRd0:  return rd[31:0];
            SelRd1:  return rd[63:32];
            SelErr:  return {31'b0, er};
            default: return {31'b0, bz};
        endcase
    endfunction

    exp_t        mon_e;
    logic [31:0] mon_act;

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_act = actual(mon_e.dut, mon_e.sel);
            n_checks++;
            if (mon_act !== mon_e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input int p, input logic [4:0] addr, input logic [31:0] d);
        waddr_a[p*5 +: 5]  = addr;
        wdata_a[p*32 +: 32] = d;
        we_a[p]            = 1'b1;
    endtask

    task automatic a_read(input int p, input logic [4:0] addr);
        raddr_a[p*5 +: 5] = addr;
    endtask

    task automatic b_write(input int p, input logic [4:0] addr, input logic [31:0] d);
        waddr_b[p*5 +: 5]  = addr;
        wdata_b[p*32 +: 32] = d;
        we_b[p]            = 1'b1;
    endtask

    task automatic b_read(input int p, input logic [4:0] addr);
        raddr_b[p*5 +: 5] = addr;
    endtask

    initial begin
        rst_a_n = 1'b0; raddr_a = '0; waddr_a = '0; wdata_a = '0; we_a = '0;
        rst_b_n = 1'b0; raddr_b = '0; waddr_b = '0; wdata_b = '0; we_b = '0;
        a_read(0, 5'd3); a_read(1, 5'd7);
        step(); step();

        // ---------------- dut_a: reset values
        expect_val("a_rst_busy", 0, SelBusy, 32'd1);
        expect_val("a_rst_err", 0, SelErr, 32'd0);
        expect_val("a_rst_rd0", 0, SelRd0, 32'd0);
        expect_val("a_rst_rd1", 0, SelRd1, 32'd0);
        step();

        // ---------------- dut_a: 32-cycle init window, write on cycle 5 dropped
        rst_a_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (k == 5) a_write(0, 5'd3, 32'hDEAD);
            if (k == 6) we_a = '0;
            expect_val("a_init_busy", 0, SelBusy, 32'd1);
            if (k == 5) begin
                expect_val("a_init_err", 0, SelErr, 32'd0);
                expect_val("a_init_rd", 0, SelRd0, 32'd0);
            end
            step();
        end
        expect_val("a_ready_busy", 0, SelBusy, 32'd0);
        expect_val("a_dropped_wr", 0, SelRd0, 32'd0);
        expect_val("a_ready_err", 0, SelErr, 32'd0);
        step();

        // ---------------- dut_a: collision, port 1 wins
        a_write(0, 5'd7, 32'h1111); a_write(1, 5'd7, 32'h2222); a_read(0, 5'd7);
        expect_val("a_coll_err", 0, SelErr, 32'd1);
        expect_val("a_coll_old", 0, SelRd0, 32'd0);
        step();
        we_a = '0;
        expect_val("a_coll_win", 0, SelRd0, 32'h2222);
        expect_val("a_coll_err_clr", 0, SelErr, 32'd0);
        step();

        // ---------------- dut_a: no bypass, one-cycle latency
        a_write(0, 5'd9, 32'hCAFE); a_read(0, 5'd9);
        expect_val("a_nobyp_old", 0, SelRd0, 32'd0);
        step();
        we_a = '0;
        expect_val("a_nobyp_new", 0, SelRd0, 32'hCAFE);
        step();

        // ---------------- dut_a: hard zero word 0
        a_write(0, 5'd0, 32'hFFFF); a_read(1, 5'd0);
        expect_val("a_w0_rd_same", 0, SelRd1, 32'd0);
        expect_val("a_w0_err_same", 0, SelErr, 32'd0);
        step();
        we_a = '0;
        expect_val("a_w0_rd", 0, SelRd1, 32'd0);
        expect_val("a_w0_err", 0, SelErr, 32'd0);
        step();

        // ---------------- dut_a: parity
        a_write(0, 5'd4, 32'h5);
        step();
        we_a = '0;
        a_read(0, 5'd4); a_read(1, 5'd5);
        expect_val("a_par_good_rd", 0, SelRd0, 32'h5);
        expect_val("a_par_good_err", 0, SelErr, 32'd0);
        step();
        force dut_a.g_word[4].g_par.par_q = 1'b1;
        #1;
        expect_val("a_par_bad_rd", 0, SelRd0, 32'h5);
        expect_val("a_par_bad_err", 0, SelErr, 32'd1);
        step();
        a_read(0, 5'd5); a_read(1, 5'd3);
        expect_val("a_par_other_err", 0, SelErr, 32'd0);
        step();
        release dut_a.g_word[4].g_par.par_q;

        // ---------------- dut_b: reset values and 24-cycle init window
        b_read(0, 5'd9);
        expect_val("b_rst_busy", 1, SelBusy, 32'd1);
        expect_val("b_rst_err", 1, SelErr, 32'd0);
        expect_val("b_rst_rd0", 1, SelRd0, 32'd0);
        step();
        rst_b_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            expect_val("b_init_busy", 1, SelBusy, 32'd1);
            step();
        end
        expect_val("b_ready_busy", 1, SelBusy, 32'd0);

        // ---------------- dut_b: same-cycle bypass
        b_write(0, 5'd9, 32'hCAFE); b_read(0, 5'd9);
        expect_val("b_byp_same", 1, SelRd0, 32'hCAFE);
        expect_val("b_byp_err", 1, SelErr, 32'd0);
        step();
        we_b = '0;
        expect_val("b_byp_stored", 1, SelRd0, 32'hCAFE);
        step();

        // ---------------- dut_b: bypass of colliding writes follows the winner
        b_write(0, 5'd12, 32'hA); b_write(1, 5'd12, 32'hB); b_read(1, 5'd12);
        expect_val("b_bcoll_rd", 1, SelRd1, 32'hB);
        expect_val("b_bcoll_err", 1, SelErr, 32'd1);
        step();
        we_b = '0;
        expect_val("b_bcoll_stored", 1, SelRd1, 32'hB);
        expect_val("b_bcoll_err_clr", 1, SelErr, 32'd0);
        step();

        // ---------------- dut_b: out-of-range write
        b_write(0, 5'd30, 32'hBEEF); b_read(0, 5'd9); b_read(1, 5'd14);
        expect_val("b_oorw_err", 1, SelErr, 32'd1);
        expect_val("b_oorw_rd0", 1, SelRd0, 32'hCAFE);
        expect_val("b_oorw_rd1", 1, SelRd1, 32'd0);
        step();
        we_b = '0;
        b_read(0, 5'd6);
        expect_val("b_oorw_w6", 1, SelRd0, 32'd0);
        expect_val("b_oorw_w14", 1, SelRd1, 32'd0);
        expect_val("b_oorw_err_clr", 1, SelErr, 32'd0);
        step();

        // ---------------- dut_b: out-of-range read
        b_read(0, 5'd25); b_read(1, 5'd12);
        expect_val("b_oorr_rd", 1, SelRd0, 32'd0);
        expect_val("b_oorr_err", 1, SelErr, 32'd1);
        expect_val("b_oorr_other", 1, SelRd1, 32'hB);
        step();

        // ---------------- dut_b: reset mid-INIT restarts the full sweep
        b_write(0, 5'd20, 32'h77);
        step();
        we_b = '0;
        b_read(0, 5'd9); b_read(1, 5'd20);
        expect_val("b_w20", 1, SelRd1, 32'h77);
        step();
        rst_b_n = 1'b0;
        step();
        rst_b_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            expect_val("b_init1_busy", 1, SelBusy, 32'd1);
            step();
        end
        rst_b_n = 1'b0;
        #1;
        expect_val("b_midrst_busy", 1, SelBusy, 32'd1);
        expect_val("b_midrst_rd", 1, SelRd1, 32'd0);
        step();
        rst_b_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            expect_val("b_init2_busy", 1, SelBusy, 32'd1);
            step();
        end
        expect_val("b_init2_done", 1, SelBusy, 32'd0);
        expect_val("b_init2_w9", 1, SelRd0, 32'd0);
        expect_val("b_init2_w20", 1, SelRd1, 32'd0);
        step();

        step();
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_register_file_mp.md
# ibex_register_file_mp

Parametrised multi-port flip-flop register file, successor to the single-write latch register file in the Ibex core. Supports configurable depth, width, read-port and write-port count, optional write-to-read bypass, and per-word parity. After reset it runs a sequential initialisation sweep so the storage flops need no reset. It sits between decode (read ports) and writeback (write ports) of the core.

## Interface
- NumWords, 32: number of architectural words, 2..64; AW = $clog2(NumWords)
- DataWidth, 32: bits per word
- NumRead, 2: read ports, 1..4
- NumWrite, 1: write ports, 1..2; a higher index has higher priority
- WriteBypass, 0: 1 = a same-cycle write is visible on reads
- ParityEn, 0: 1 = store one even-parity bit per word and check it on every read
- HardZeroWord0, 1: word 0 always reads WordZeroVal; writes to it are discarded
- WordZeroVal, '0: init/zero value
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous and active-low
- raddr_i  in  NumRead*AW  read addresses, port p at [p*AW +: AW]
- rdata_o  out  NumRead*DataWidth  read data, port p at [p*DataWidth +: DataWidth]
- waddr_i  in  NumWrite*AW  write addresses
- wdata_i  in  NumWrite*DataWidth  write data
- we_i  in  NumWrite  write enables
- init_busy_o  out  1  init sweep in progress
- err_o  out  1  error this cycle: parity, collision or range

## Operation
- Init FSM states: INIT, READY. Reset forces INIT with the word counter at 0 and init_busy_o=1.
- In INIT, each cycle writes WordZeroVal and its parity bit to word[counter], then increments the counter. The FSM moves to READY after word NumWords-1 is written, so INIT lasts NumWords cycles. init_busy_o is 0 in READY.
- During INIT: all we_i are ignored (dropped, not queued), every rdata_o returns WordZeroVal, and err_o=0.
- In READY, a write from port w updates word[waddr] at the clock edge when we_i[w]=1.
- Collision: if both write ports are enabled to the same address, port 1 wins and err_o=1 for that cycle.
- Out-of-range address (index >= NumWords, possible only when NumWords is not a power of two):
  - a write to it is discarded and sets err_o=1;
  - a read of it returns WordZeroVal and sets err_o=1.
- Reads are combinational from storage.
- With WriteBypass=1, a read whose address matches an enabled write returns the winning write's wdata in the same cycle. Word 0 is never bypassed when HardZeroWord0=1.
- With ParityEn=1, err_o=1 whenever any read port's stored parity mismatches its data. The data is still returned. Word 0 is exempt when HardZeroWord0=1.
- err_o is combinational: the OR of all conditions in the current cycle, and is not sticky.
- Reset during INIT or READY restarts INIT from word 0. Storage contents are not reset directly.

## Timing
- Reset values: init_busy_o=1, err_o=0, every rdata_o=WordZeroVal.
- Write-to-read latency: 1 cycle without bypass, 0 cycles with bypass.
- The first write accepted is at cycle NumWords after reset release (cycle 0 is the first edge with rst_ni high).
- There is no backpressure. The core must stall writeback while init_busy_o=1.

## Structure
- Package ibex_rf_pkg holds:
  - the enum rf_init_e {RfInit, RfReady};
  - the function rf_parity(data), returning ^data;
  - the localparam helper for AW.
- Sub-module ibex_register_file_mp_init: the FSM plus the AW-bit counter. It outputs init_busy, init_we and init_addr, and the top level muxes these into the write path.
- Storage is a generate loop of per-word DataWidth(+1) flops without reset. The priority write decode and the read muxes are generated per port.

## Test plan
- Reset, NumWords=32: init_busy_o=1 for exactly 32 cycles. A write on cycle 5 (0xDEAD, addr 3) is dropped, and word 3 reads 0 after init.
- READY, NumWrite=2, both ports write addr 7 (0x1111 on port 0, 0x2222 on port 1) → err_o=1 that cycle; the next cycle port 0 reads 0x2222.
- WriteBypass=1, write 0xCAFE to addr 9 while reading addr 9 → rdata 0xCAFE in the same cycle. With WriteBypass=0, the old value is returned and 0xCAFE appears one cycle later.
- HardZeroWord0=1, write 0xFFFF to addr 0 → reads 0 with err_o=0.
- ParityEn=1: write 0x5 to addr 4, then force the stored parity bit to flip → a read of addr 4 returns 0x5 with err_o=1; a read of addr 5 gives err_o=0.
- NumWords=24: write to addr 30 → err_o=1 and no word changes. Then assert rst_ni low mid-INIT at counter 10 → INIT restarts and the full 24-cycle busy window repeats.
